// File: rtl/gcd_controller.sv
// Control FSM for a 16-bit subtract-based GCD datapath: operand fetch over
// valid/ready, one subtraction per cycle, iteration watchdog. Optional: GCD_CTRL_ABORT_EN.
module gcd_controller #(
    parameter int CNT_W    = 16,
    parameter int MAX_ITER = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             lt,
    input  logic             gt,
    input  logic             eq,
    output logic             lda,
    output logic             ldb,
    output logic             sel1,
    output logic             sel2,
    output logic             selin,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] iter_count
`ifdef GCD_CTRL_ABORT_EN
    ,
    input  logic             abort
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_ITERATE,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] iter_q, iter_d;
    logic             err_q, err_d;
    logic             abort_hit;

`ifdef GCD_CTRL_ABORT_EN
    assign abort_hit = abort & (state_q != S_IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        iter_d   = iter_q;
        err_d    = err_q;
        in_ready = 1'b0;
        lda      = 1'b0;
        ldb      = 1'b0;
        sel1     = 1'b0;
        sel2     = 1'b0;
        selin    = 1'b0;
        done     = 1'b0;
        busy     = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD_A;
                    iter_d  = '0;
                    err_d   = 1'b0;
                end
            end
            S_LOAD_A: begin
                selin    = 1'b1;
                in_ready = 1'b1;
                lda      = in_valid;
                if (in_valid) state_d = S_LOAD_B;
            end
            S_LOAD_B: begin
                selin    = 1'b1;
                in_ready = 1'b1;
                ldb      = in_valid;
                if (in_valid) state_d = S_ITERATE;
            end
            S_ITERATE: begin
                // A missing flag is treated like equality so the run still ends
                if (eq || !(gt || lt)) begin
                    state_d = S_DONE;
                end else if (iter_q == MAX_CNT) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else if (gt) begin
                    sel2   = 1'b1;
                    lda    = 1'b1;
                    iter_d = iter_q + 1'b1;
                end else begin
                    sel1   = 1'b1;
                    ldb    = 1'b1;
                    iter_d = iter_q + 1'b1;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort drops straight to IDLE, suppressing loads and completion status
        if (abort_hit) begin
            lda      = 1'b0;
            ldb      = 1'b0;
            in_ready = 1'b0;
            done     = 1'b0;
            state_d  = S_IDLE;
            iter_d   = iter_q;
            err_d    = err_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            iter_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            err_q   <= err_d;
        end
    end

    assign err        = err_q;
    assign iter_count = iter_q;

endmodule

// File: tb/tb_gcd_controller.sv
// Bench for gcd_controller: a register-level GCD datapath, a trace-building
// reference model (Euclid by subtraction) and a per-cycle output comparator.
module tb_gcd_controller;

    localparam int CNT_W    = 16;
    localparam int MAX_ITER = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             in_valid = 1'b0;
    logic             abort = 1'b0;
    logic             in_ready, lt, gt, eq, lda, ldb, sel1, sel2, selin;
    logic             busy, done, err;
    logic [CNT_W-1:0] iter_count;
    logic [15:0]      data_in = 16'd0;
    logic [15:0]      dp_a = 16'd0, dp_b = 16'd0;

    always #5 clk = ~clk;

    gcd_controller #(.CNT_W(CNT_W), .MAX_ITER(MAX_ITER)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .lt(lt), .gt(gt), .eq(eq),
        .lda(lda), .ldb(ldb), .sel1(sel1), .sel2(sel2), .selin(selin),
        .busy(busy), .done(done), .err(err),
`ifdef GCD_CTRL_ABORT_EN
        .abort(abort),
`endif
        .iter_count(iter_count)
    );

    // Datapath the controller steers
    wire [15:0] sub_a = sel1 ? dp_b : dp_a;
    wire [15:0] sub_b = sel2 ? dp_b : dp_a;
    wire [15:0] bus   = selin ? data_in : (sub_a - sub_b);
    assign lt = dp_a < dp_b;
    assign gt = dp_a > dp_b;
    assign eq = dp_a == dp_b;
    always @(posedge clk) begin
        if (lda) dp_a <= bus;
        if (ldb) dp_b <= bus;
    end

    typedef struct packed {
        logic in_ready, lda, ldb, sel1, sel2, selin, busy, done, err;
    } outs_t;

    typedef struct {
        bit          chk;
        logic        start, in_valid, rst, abort;
        logic [15:0] din;
        outs_t       exp;
        logic [15:0] iter;
        bit          chk_res;
        logic [15:0] res;
    } ent_t;

    ent_t plan[$];
    ent_t chkq[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    logic m_err = 1'b0;
    logic [15:0] m_iter = 16'd0;

    function automatic ent_t idle_ent();
        ent_t e;
        e = '{default: 0};
        e.chk     = 1'b1;
        e.exp.err = m_err;
        e.iter    = m_iter;
        return e;
    endfunction

    function automatic ent_t busy_ent();
        ent_t e;
        e = idle_ent();
        e.exp.busy = 1'b1;
        return e;
    endfunction

    // Expected per-cycle trace of one run, derived from subtraction Euclid
    task automatic build_run(input logic [15:0] a, input logic [15:0] b,
                             input int lows_a, input int lows_b, input bit start_busy,
                             input int rst_at, input bit abort_b,
                             output int n, output logic [15:0] res, output int done_idx);
        ent_t e;
        int   idx;
        logic [15:0] x, y;
        n = 0; res = 16'd0; done_idx = -1;
        e = idle_ent(); e.start = 1'b1; plan.push_back(e); idx = 1;
        m_err = 1'b0; m_iter = 16'd0;
        for (int k = 0; k <= lows_a; k++) begin
            e = busy_ent(); e.start = start_busy; e.din = a;
            e.exp.selin = 1'b1; e.exp.in_ready = 1'b1;
            if (k == lows_a) begin e.in_valid = 1'b1; e.exp.lda = 1'b1; end
            plan.push_back(e); idx++;
        end
        for (int k = 0; k <= lows_b; k++) begin
            e = busy_ent(); e.start = start_busy; e.din = b;
            e.exp.selin = 1'b1; e.exp.in_ready = 1'b1;
            if (k == lows_b) begin
                e.in_valid = 1'b1;
                if (abort_b) begin
                    e.abort = 1'b1; e.exp.in_ready = 1'b0;
                    plan.push_back(e);
                    plan.push_back(idle_ent());
                    return;
                end
                e.exp.ldb = 1'b1;
            end
            plan.push_back(e); idx++;
        end
        x = a; y = b;
        while (x != y && n < MAX_ITER) begin
            e = busy_ent(); e.start = start_busy; e.iter = 16'(n);
            if (x > y) begin e.exp.lda = 1'b1; e.exp.sel2 = 1'b1; end
            else       begin e.exp.ldb = 1'b1; e.exp.sel1 = 1'b1; end
            if (rst_at == n) begin
                e.rst = 1'b1; plan.push_back(e);
                m_iter = 16'd0; m_err = 1'b0;
                plan.push_back(idle_ent());
                return;
            end
            if (x > y) x = x - y; else y = y - x;
            plan.push_back(e); idx++; n++;
        end
        e = busy_ent(); e.start = start_busy; e.iter = 16'(n);
        plan.push_back(e); idx++;
        m_iter = 16'(n);
        m_err  = (x != y);
        e = busy_ent(); e.start = start_busy; e.exp.done = 1'b1;
        e.chk_res = (x == y); e.res = x;
        plan.push_back(e); done_idx = idx;
        plan.push_back(idle_ent());
        res = x;
    endtask

    task automatic run_plan();
        ent_t e;
        while (plan.size() > 0) begin
            e = plan.pop_front();
            @(posedge clk); #1;
            rst = e.rst; start = e.start; in_valid = e.in_valid;
            abort = e.abort; data_in = e.din;
            chkq.push_back(e);
        end
        @(negedge clk); #1;
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        ent_t  e;
        outs_t act;
        cyc++;
        if (chkq.size() > 0) begin
            e = chkq.pop_front();
            if (e.chk) begin
                act = {in_ready, lda, ldb, sel1, sel2, selin, busy, done, err};
                n_checks++;
                if (act !== e.exp) begin
                    n_errors++;
                    $display("FAIL outputs cycle %0d: got %b expected %b (rdy,lda,ldb,s1,s2,sin,busy,done,err)",
                             cyc, act, e.exp);
                end
                n_checks++;
                if (iter_count !== e.iter) begin
                    n_errors++;
                    $display("FAIL iter_count cycle %0d: got %0d expected %0d", cyc, iter_count, e.iter);
                end
                if (e.chk_res) begin
                    n_checks++;
                    if (dp_a !== e.res || dp_b !== e.res) begin
                        n_errors++;
                        $display("FAIL result cycle %0d: got A=%0d B=%0d expected %0d", cyc, dp_a, dp_b, e.res);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ent_t e;
        int n, di;
        logic [15:0] r;

        e = idle_ent(); e.chk = 1'b0; e.rst = 1'b1;
        plan.push_back(e); plan.push_back(e);
        plan.push_back(idle_ent());
        run_plan();
        $display("reset: iter=%0d err=%0d busy=%0d", iter_count, err, busy);

        build_run(16'd12, 16'd8, 0, 0, 1'b0, -1, 1'b0, n, r, di);
        check_val("model_12_8_iters", n, 2);
        check_val("model_12_8_result", r, 4);
        check_val("model_12_8_done_cycle", di, 6);
        run_plan();
        check_val("dut_12_8_iter_count", iter_count, 2);
        check_val("dut_12_8_result", dp_a, 4);
        check_val("dut_12_8_err", err, 0);
        $display("run 12,8: result=%0d iters=%0d err=%0d", dp_a, iter_count, err);

        build_run(16'd48, 16'd18, 0, 0, 1'b0, -1, 1'b0, n, r, di);
        check_val("model_48_18_iters", n, 4);
        check_val("model_48_18_result", r, 6);
        run_plan();
        check_val("dut_48_18_result", dp_a, 6);
        $display("run 48,18: result=%0d iters=%0d err=%0d", dp_a, iter_count, err);

        build_run(16'd7, 16'd7, 0, 0, 1'b0, -1, 1'b0, n, r, di);
        check_val("model_7_7_done_cycle", di, 4);
        run_plan();
        $display("run 7,7: result=%0d iters=%0d err=%0d", dp_a, iter_count, err);

        build_run(16'd0, 16'd0, 0, 0, 1'b0, -1, 1'b0, n, r, di);
        run_plan();
        check_val("dut_0_0_err", err, 0);
        $display("run 0,0: result=%0d iters=%0d err=%0d", dp_a, iter_count, err);

        build_run(16'd35, 16'd21, 3, 2, 1'b0, -1, 1'b0, n, r, di);
        check_val("model_35_21_result", r, 7);
        run_plan();
        $display("run 35,21 stalled: result=%0d iters=%0d err=%0d", dp_a, iter_count, err);

        build_run(16'd0, 16'd5, 0, 0, 1'b0, -1, 1'b0, n, r, di);
        check_val("model_0_5_iters", n, MAX_ITER);
        run_plan();
        check_val("dut_0_5_err_sticky", err, 1);
        check_val("dut_0_5_iter_count", iter_count, MAX_ITER);
        $display("run 0,5 timeout: iters=%0d err=%0d", iter_count, err);

        build_run(16'd9, 16'd6, 0, 0, 1'b1, 1, 1'b0, n, r, di);
        run_plan();
        check_val("dut_rst_iter_count", iter_count, 0);
        check_val("dut_rst_busy", busy, 0);
        $display("run 9,6 reset mid-run with start held: iters=%0d busy=%0d", iter_count, busy);

        build_run(16'd9, 16'd6, 0, 0, 1'b0, -1, 1'b0, n, r, di);
        check_val("model_9_6_iters", n, 2);
        run_plan();
        check_val("dut_9_6_result", dp_a, 3);
        $display("run 9,6: result=%0d iters=%0d err=%0d", dp_a, iter_count, err);

`ifdef GCD_CTRL_ABORT_EN
        build_run(16'd10, 16'd4, 0, 0, 1'b0, -1, 1'b1, n, r, di);
        run_plan();
        check_val("dut_abort_busy", busy, 0);
        $display("run 10,4 aborted in LOAD_B: busy=%0d iters=%0d", busy, iter_count);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
